// File: rtl/tdm_rx.sv
// rtl/tdm_rx.sv - two-slot TDM serial receiver with frame-sync alignment
//
// Ports:
//   in_mclk          system clock; every register updates on its rising edge
//   in_rst           asynchronous active-high reset
//   in_sclk          TDM bit clock, synchronous to in_mclk, at most in_mclk/2
//   in_fclk          frame sync, high for one sclk period before slot 0
//   in_din           serial data, MSB first, changes on sclk falling edge
//   out_frame_1      slot 0 word (first G_BITS bits after sync)
//   out_frame_2      slot 1 word (next G_BITS bits)
//   out_frame_strobe one-cycle pulse: out_frame_1/2 newly valid
//   out_sync_err     one-cycle pulse: frame sync arrived before frame complete
//   out_locked       high while the receiver is frame-aligned
module tdm_rx #(
    parameter int G_BITS = 16
) (
    input  logic              in_mclk,
    input  logic              in_rst,
    input  logic              in_sclk,
    input  logic              in_fclk,
    input  logic              in_din,
    output logic [G_BITS-1:0] out_frame_1,
    output logic [G_BITS-1:0] out_frame_2,
    output logic              out_frame_strobe,
    output logic              out_sync_err,
    output logic              out_locked
);

    localparam int FRAME_BITS = 2 * G_BITS;
    // Must hold FRAME_BITS itself, since "counter == FRAME_BITS" marks a full frame.
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_reg;

    // Capture stage: the bus pins are sampled once, then sclk is delayed once
    // more so its rising edge can be found without a second clock domain.
    logic sclk_q;
    logic sclk_prev;
    logic fclk_q;
    logic din_q;
    logic sclk_edge;

    assign sclk_edge = sclk_q & ~sclk_prev;

    always_ff @(posedge in_mclk or posedge in_rst) begin
        if (in_rst) begin
            sclk_q    <= 1'b0;
            sclk_prev <= 1'b0;
            fclk_q    <= 1'b0;
            din_q     <= 1'b0;
        end else begin
            sclk_q    <= in_sclk;
            sclk_prev <= sclk_q;
            fclk_q    <= in_fclk;
            din_q     <= in_din;
        end
    end

    always_ff @(posedge in_mclk or posedge in_rst) begin
        if (in_rst) begin
            state            <= ST_HUNT;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            out_frame_1      <= '0;
            out_frame_2      <= '0;
            out_frame_strobe <= 1'b0;
            out_sync_err     <= 1'b0;
            out_locked       <= 1'b0;
        end else begin
            out_frame_strobe <= 1'b0;
            out_sync_err     <= 1'b0;

            case (state)
                ST_HUNT: begin
                    // The bit under the sync pulse is a dummy and is dropped.
                    if (sclk_edge && fclk_q) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end

                ST_SHIFT: begin
                    // The full-frame test runs in the cycle after the last bit
                    // was shifted; sclk is at most mclk/2, so no edge can land
                    // in that same cycle.
                    if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                        out_frame_1      <= shift_reg[FRAME_BITS-1:G_BITS];
                        out_frame_2      <= shift_reg[G_BITS-1:0];
                        out_frame_strobe <= 1'b1;
                        out_locked       <= 1'b1;
                        state            <= ST_WAIT;
                    end else if (sclk_edge) begin
                        if (fclk_q) begin
                            // Early sync: drop the partial frame and realign on
                            // this pulse; published words are left untouched.
                            out_sync_err <= 1'b1;
                            out_locked   <= 1'b0;
                            bit_cnt      <= '0;
                            shift_reg    <= '0;
                        end else begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], din_q};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    // Any slots beyond the second are ignored until next sync.
                    if (sclk_edge && fclk_q) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end

                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_rx.sv
// tb/tb_tdm_rx.sv - scoreboard testbench for tdm_rx
module tb_tdm_rx;

    localparam int G_BITS = 16;

    logic              mclk;
    logic              rst;
    logic              sclk;
    logic              fclk;
    logic              din;
    logic [G_BITS-1:0] frame_1;
    logic [G_BITS-1:0] frame_2;
    logic              strobe;
    logic              sync_err;
    logic              locked;

    tdm_rx #(.G_BITS(G_BITS)) dut (
        .in_mclk          (mclk),
        .in_rst           (rst),
        .in_sclk          (sclk),
        .in_fclk          (fclk),
        .in_din           (din),
        .out_frame_1      (frame_1),
        .out_frame_2      (frame_2),
        .out_frame_strobe (strobe),
        .out_sync_err     (sync_err),
        .out_locked       (locked)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_err     = 0;
    int err_seen    = 0;
    int strobe_seen = 0;

    logic [31:0] fr_q[$];
    int          lat_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One sclk period: fall (fclk/din change), then rise. Marked periods carry
    // the last data bit; the strobe is due 2 mclk edges after the edge that
    // first sees sclk high, i.e. at the sample point with cyc + 3.
    task automatic period(input logic f, input logic d, input int half, input logic mark);
        sclk = 1'b0;
        fclk = f;
        din  = d;
        repeat (half) @(negedge mclk);
        sclk = 1'b1;
        if (mark) lat_q.push_back(cyc + 3);
        repeat (half) @(negedge mclk);
    endtask

    task automatic sync(input int half);
        period(1'b1, 1'($urandom), half, 1'b0);
    endtask

    task automatic bits(input logic [63:0] w, input int n, input int half, input logic mark);
        for (int i = n - 1; i >= 0; i--)
            period(1'b0, w[i], half, mark && (i == 0));
    endtask

    task automatic frame(input logic [15:0] f1, input logic [15:0] f2, input int half);
        fr_q.push_back({f1, f2});
        sync(half);
        bits({32'h0, f1, f2}, 32, half, 1'b1);
    endtask

    // Output monitor: every strobe must match the oldest expected frame.
    always @(negedge mclk) begin
        if (!rst) begin
            if (sync_err) err_seen++;
            if (strobe) begin
                strobe_seen++;
                if (fr_q.size() == 0 || lat_q.size() == 0) begin
                    check("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    logic [31:0] e;
                    int          l;
                    e = fr_q.pop_front();
                    l = lat_q.pop_front();
                    check("frame_1", 64'(frame_1), 64'(e[31:16]));
                    check("frame_2", 64'(frame_2), 64'(e[15:0]));
                    check("locked_at_strobe", 64'(locked), 64'd1);
                    check("strobe_latency", 64'(cyc), 64'(l));
                end
            end
        end
    end

    initial begin
        logic [31:0] junk;
        rst  = 1'b1;
        sclk = 1'b0;
        fclk = 1'b0;
        din  = 1'b0;
        repeat (3) @(negedge mclk);
        check("rst_frame_1", 64'(frame_1), 64'd0);
        check("rst_frame_2", 64'(frame_2), 64'd0);
        check("rst_strobe", 64'(strobe), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst = 1'b0;

        // Bits with no sync yet: receiver must stay in hunt.
        for (int i = 0; i < 40; i++) period(1'b0, 1'($urandom), 1, 1'b0);
        repeat (4) @(negedge mclk);
        check("hunt_frame_1", 64'(frame_1), 64'd0);
        check("hunt_frame_2", 64'(frame_2), 64'd0);
        check("hunt_locked", 64'(locked), 64'd0);

        // Basic frame.
        frame(16'hA5C3, 16'h1234, 1);
        period(1'b0, 1'b1, 1, 1'b0);
        period(1'b0, 1'b0, 1, 1'b0);
        check("basic_locked", 64'(locked), 64'd1);

        // Back-to-back frames, sync directly after bit 32.
        frame(16'hFFFF, 16'h0000, 1);
        frame(16'h8001, 16'h7FFE, 1);
        period(1'b0, 1'b0, 1, 1'b0);
        check("b2b_no_sync_err", 64'(err_seen), 64'd0);
        check("b2b_locked", 64'(locked), 64'd1);

        // Early sync after 20 bits; the early sync pulse starts the next frame.
        sync(1);
        junk = $urandom;
        bits({44'h0, junk[19:0]}, 20, 1, 1'b0);
        fr_q.push_back(32'h0F0FF0F0);
        period(1'b1, 1'b0, 1, 1'b0);
        exp_err++;
        repeat (2) @(negedge mclk);
        check("err_pulse_count", 64'(err_seen), 64'(exp_err));
        check("err_locked", 64'(locked), 64'd0);
        check("err_frame_1_held", 64'(frame_1), 64'h8001);
        check("err_frame_2_held", 64'(frame_2), 64'h7FFE);
        bits({32'h0, 32'h0F0FF0F0}, 32, 1, 1'b1);
        period(1'b0, 1'b0, 1, 1'b0);
        check("relock", 64'(locked), 64'd1);

        // Reset in the middle of a frame.
        sync(1);
        junk = $urandom;
        bits({54'h0, junk[9:0]}, 10, 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_frame_1", 64'(frame_1), 64'd0);
        check("async_rst_frame_2", 64'(frame_2), 64'd0);
        check("async_rst_locked", 64'(locked), 64'd0);
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        frame(16'hBEEF, 16'hCAFE, 1);
        period(1'b0, 1'b0, 1, 1'b0);

        // Slow bit clock, four slots on the bus; only slots 0-1 are reported.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] w;
            logic [31:0] extra;
            w     = $urandom;
            extra = $urandom | 32'h0001_0001;
            fr_q.push_back(w);
            sync(4);
            bits({32'h0, w}, 32, 4, 1'b1);
            bits({32'h0, extra}, 32, 4, 1'b0);
        end

        repeat (20) @(negedge mclk);
        check("pending_frames", 64'(fr_q.size()), 64'd0);
        check("total_strobes", 64'(strobe_seen), 64'd7);
        check("total_sync_errs", 64'(err_seen), 64'(exp_err));
        check("final_locked", 64'(locked), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_rx.md
TDM_RX -- requirements
Module: tdm_rx

Interface
REQ-001 SHALL have parameter G_BITS, default 16: bits per channel slot; frame = 2 slots = 2*G_BITS data bits.
REQ-002 SHALL have port in_mclk  input  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port in_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_sclk  input  1  TDM bit clock, synchronous to in_mclk, at most in_mclk/2.
REQ-005 SHALL have port in_fclk  input  1  frame sync, one sclk period high, changes on sclk falling edge.
REQ-006 SHALL have port in_din  input  1  serial data, MSB first, changes on sclk falling edge.
REQ-007 SHALL have port out_frame_1  output  G_BITS  slot 0 word (first G_BITS bits after sync).
REQ-008 SHALL have port out_frame_2  output  G_BITS  slot 1 word (next G_BITS bits).
REQ-009 SHALL have port out_frame_strobe  output  1  one-cycle pulse: out_frame_1/2 newly valid.
REQ-010 SHALL have port out_sync_err  output  1  one-cycle pulse: frame sync arrived before frame complete.
REQ-011 SHALL have port out_locked  output  1  high while receiver is frame-aligned.

Function
REQ-012 SHALL register in_sclk, in_fclk, in_din once on in_mclk (capture stage) and keep the previous captured sclk.
REQ-013 SHALL detect an sclk rising edge as captured sclk = 1 and previous captured sclk = 0; all bit actions occur only in that cycle.
REQ-014 SHALL implement states HUNT, SHIFT, WAIT; reset state HUNT.
REQ-015 HUNT: at sclk edge with fclk = 1 -> SHIFT, bit counter = 0; din sampled at that edge is discarded (dummy bit); other edges ignored.
REQ-016 SHIFT, fclk = 0: shift captured din into a 2*G_BITS shift register LSB-side, counter += 1.
REQ-017 SHIFT, when counter reaches 2*G_BITS (edge sampling the last bit): next cycle out_frame_1 = shift[2*G_BITS-1:G_BITS], out_frame_2 = shift[G_BITS-1:0], out_frame_strobe = 1 for exactly one in_mclk cycle, out_locked = 1; state -> WAIT.
REQ-018 Strobe latency: exactly 2 in_mclk cycles after the in_mclk edge on which in_sclk is first seen high for the last data bit.
REQ-019 WAIT: data bits ignored (extra slots on bus discarded); edge with fclk = 1 -> SHIFT, counter = 0, dummy bit discarded.
REQ-020 SHIFT, edge with fclk = 1 while counter < 2*G_BITS: next cycle out_sync_err = 1 for one cycle, out_locked = 0, partial frame discarded, outputs frame_1/2 unchanged, restart SHIFT with counter = 0.
REQ-021 Simultaneous last data bit and fclk = 1 at same edge is impossible per protocol; SHALL treat as REQ-020 (error wins, no strobe).
REQ-022 out_frame_1/2 SHALL hold value between strobes; change only in the cycle out_frame_strobe is high.
REQ-023 Counter SHALL be wide enough for 2*G_BITS without wrap; no wrap behaviour required beyond REQ-017.
REQ-024 out_locked SHALL stay high across consecutive correct frames, including WAIT.

Reset
REQ-025 in_rst high SHALL immediately force: state HUNT, counter 0, shift register 0, capture registers 0, out_frame_1 = 0, out_frame_2 = 0, out_frame_strobe = 0, out_sync_err = 0, out_locked = 0.
REQ-026 Reset mid-frame SHALL discard partial data; after release, no strobe until a full frame following a new fclk.

Verification
REQ-027 G_BITS=16, sclk = mclk/2, fclk then bits 0xA5C3 then 0x1234 -> one strobe, out_frame_1 = 0xA5C3, out_frame_2 = 0x1234, out_locked = 1, latency per REQ-018.
REQ-028 Back-to-back frames 0xFFFF/0x0000 then 0x8001/0x7FFE with fclk immediately after bit 32 -> two strobes, values correct, out_sync_err never high.
REQ-029 fclk re-asserted after 20 bits -> out_sync_err one-cycle pulse, out_locked = 0, no strobe, next full frame 0x0F0F/0xF0F0 strobes correctly.
REQ-030 Bits before first fclk (e.g. 40 random bits) -> no strobe; outputs stay 0.
REQ-031 in_rst asserted after 10 bits of a frame -> outputs 0 asynchronously; following complete frame 0xBEEF/0xCAFE strobes correctly.
REQ-032 sclk = mclk/8, 4 slots on bus, slots 2-3 nonzero -> only slots 0-1 reported, one strobe per frame.
